rx_deserializer: RTL and testbench

RX_DESERIALIZER -- requirements
Module: rx_deserializer

---
 rtl/rx_deserializer.sv | 104 ++++++++++
 tb/tb_rx_deserializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rx_deserializer.sv
// Serial frame receiver: start, 7 data bits LSB first, even parity, stop.
// Line is synchronous to clk, so serial_in is sampled directly every edge.
module rx_deserializer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       serial_in,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  state_e     state_q,     state_d;
  logic [2:0] cnt_q,       cnt_d;
  logic [6:0] shreg_q,     shreg_d;
  logic       rx_parity_q, rx_parity_d;
  logic [6:0] data_q,      data_d;
  logic       valid_q,     valid_d;
  logic       perr_q,      perr_d;
  logic       ferr_q,      ferr_d;
  logic       busy_q,      busy_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_parity_d = rx_parity_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d = DATA;
          cnt_d   = 3'd0;
        end
      end
      DATA: begin
        // Shift in at the MSB so d0 ends up in bit 0 after seven bits.
        shreg_d = {serial_in, shreg_q[6:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = PARITY;
      end
      PARITY: begin
        rx_parity_d = serial_in;
        state_d     = STOP;
      end
      STOP: begin
        // The stop edge is never a start candidate, even when the line is 0.
        data_d  = shreg_q;
        perr_d  = (^shreg_q) ^ rx_parity_q;
        ferr_d  = ~serial_in;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shreg_q     <= 7'h00;
      rx_parity_q <= 1'b0;
      data_q      <= 7'h00;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_parity_q <= rx_parity_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Scoreboard bench for rx_deserializer: frames are built bit by bit, expected
// results queued at send time and checked by a free-running monitor.
module tb_rx_deserializer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       serial_in = 1'b1;
  logic [6:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  rx_deserializer dut (
    .clk        (clk),
    .rstn       (rstn),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_frames = 0;
  logic exp_busy = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One line bit per cycle; busy_after is what busy must read after the edge sampling it.
  task automatic send_bit(input logic b, input logic busy_after);
    @(negedge clk);
    serial_in = b;
    exp_busy  = busy_after;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
  endtask

  // Frame with caller-chosen parity and stop bits; outcome follows from the frame rules.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop);
    exp_t e;
    @(negedge clk);
    e.data = d;
    e.perr = (^d) ^ p;
    e.ferr = ~stop;
    e.cyc  = cyc + 10;
    q.push_back(e);
    serial_in = 1'b0;
    exp_busy  = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(d[i], 1'b1);
    send_bit(p, 1'b1);
    send_bit(stop, 1'b0);
  endtask

  task automatic send_good(input logic [6:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    last_exp = '{data: 7'h00, perr: 1'b0, ferr: 1'b0, cyc: 0};
    forever begin
      @(posedge clk);
      #1;
      if (rstn) check("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (data_valid) begin
        check("valid_not_consecutive", {31'd0, prev_valid}, 32'd0);
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got data %0h with no frame outstanding", data_out);
        end else begin
          e = q.pop_front();
          n_frames++;
          check("sb_data", {25'd0, data_out}, {25'd0, e.data});
          check("sb_parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          check("sb_frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          check("sb_valid_cycle", cyc, e.cyc);
          last_exp = e;
        end
      end else begin
        check("hold_outputs", {23'd0, data_out, parity_err, frame_err},
              {23'd0, last_exp.data, last_exp.perr, last_exp.ferr});
      end
      prev_valid = data_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] d;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_out", {25'd0, data_out}, 32'd0);
    check("rst_flags", {28'd0, data_valid, parity_err, frame_err, busy}, 32'd0);
    rstn = 1'b1;
    idle(2);

    send_frame(7'h55, 1'b0, 1'b1);    // good frame, p=0
    idle(2);
    send_frame(7'h01, 1'b1, 1'b1);    // good frame, p=1
    idle(1);
    send_frame(7'h01, 1'b0, 1'b1);    // bad parity, still pulses
    idle(3);
    send_good(7'h7F);                 // back-to-back pair
    send_good(7'h00);
    idle(2);
    send_frame(7'h2A, 1'b1, 1'b0);    // frame error, stop sampled 0
    idle(3);

    // Reset mid-frame after d3 of 7'h33
    d = 7'h33;
    @(negedge clk);
    serial_in = 1'b0;
    exp_busy  = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b1);
    @(negedge clk);
    rstn      = 1'b0;
    serial_in = 1'b1;
    exp_busy  = 1'b0;
    last_exp  = '{data: 7'h00, perr: 1'b0, ferr: 1'b0, cyc: 0};
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_data", {25'd0, data_out}, 32'd0);
    check("async_rst_flags", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    send_good(7'h11);
    idle(1);

    // Frame error with line held low: the next 0 starts a new frame at once
    send_frame(7'h15, ^7'h15, 1'b0);
    send_good(7'h6B);
    idle(2);

    // Loopback of a random stream, correct parity, random idle gaps
    for (int i = 0; i < 40; i++) begin
      d = 7'($urandom_range(0, 127));
      send_good(d);
      idle(int'($urandom_range(0, 3)));
    end

    // Random error injection
    for (int i = 0; i < 20; i++) begin
      d = 7'($urandom_range(0, 127));
      send_frame(d, (^d) ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(12);
    check("sb_drained", q.size(), 32'd0);
    check("frames_seen", n_frames, 32'd69);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
